// File: rtl/acc_cpu_pkg.sv
// Shared widths, opcodes and instruction field helpers for the accumulator CPU.
package acc_cpu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned INSTR_W   = OPC_W + DATA_W;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'h7;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'h8;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'h9;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hA;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hB;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'hC;
  localparam logic [OPC_W-1:0] OP_JC   = 4'hD;

  // Opcode field of an instruction word
  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1:DATA_W];
  endfunction

  // Immediate field of an instruction word
  function automatic logic [DATA_W-1:0] instr_imm(input logic [INSTR_W-1:0] w);
    return w[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/acc_cpu_imem.sv
// Instruction RAM: async clear to NOP, synchronous write, combinational read.
module acc_cpu_imem
  import acc_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata_c
);

  logic [INSTR_W-1:0] mem_q [MEM_DEPTH];
  logic [INSTR_W-1:0] mem_d [MEM_DEPTH];

  // Next memory contents: single-word update on a write
  always_comb begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage; reset wipes every word back to NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/accumulator_cpu.sv
// Single-cycle 8-bit accumulator core with a loadable 16-word instruction RAM.
// Optional branch opcodes (JMP/JZ/JC) are enabled by defining ACC_CPU_BRANCH_EN.
module accumulator_cpu
  import acc_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [DATA_W-1:0]  AC,
  output logic [ADDR_W-1:0]  PC,
  output logic               halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  ac_q, ac_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic [INSTR_W-1:0] ir_c;
  logic [OPC_W-1:0]   opc;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W:0]    add_res;
  logic [DATA_W:0]    sub_res;
  logic               upd_z;

  acc_cpu_imem u_imem (
    .clk     (clk),
    .rst_n   (reset),
    .we      (we),
    .waddr   (instr_addr),
    .wdata   (instr_in),
    .raddr   (pc_q),
    .rdata_c (ir_c)
  );

  // Decode, ALU, flag and PC update; writes and halt both freeze execution
  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    upd_z   = 1'b0;
    opc     = instr_opcode(ir_c);
    imm     = instr_imm(ir_c);
    add_res = {1'b0, ac_q} + {1'b0, imm};
    sub_res = {1'b0, ac_q} - {1'b0, imm};

    if (!we && state_q == ST_RUN) begin
      pc_d = pc_q + ADDR_W'(1);
      case (opc)
        OP_LOAD: begin
          ac_d  = imm;
          upd_z = 1'b1;
        end
        OP_ADD: begin
          ac_d    = add_res[DATA_W-1:0];
          carry_d = add_res[DATA_W];
          upd_z   = 1'b1;
        end
        OP_SUB: begin
          // Top bit of the widened difference is the borrow (AC < imm)
          ac_d    = sub_res[DATA_W-1:0];
          carry_d = sub_res[DATA_W];
          upd_z   = 1'b1;
        end
        OP_AND: begin
          ac_d  = ac_q & imm;
          upd_z = 1'b1;
        end
        OP_OR: begin
          ac_d  = ac_q | imm;
          upd_z = 1'b1;
        end
        OP_XOR: begin
          ac_d  = ac_q ^ imm;
          upd_z = 1'b1;
        end
        OP_NOT: begin
          ac_d  = ~ac_q;
          upd_z = 1'b1;
        end
        OP_SHL: begin
          ac_d    = {ac_q[DATA_W-2:0], 1'b0};
          carry_d = ac_q[DATA_W-1];
          upd_z   = 1'b1;
        end
        OP_SHR: begin
          ac_d    = {1'b0, ac_q[DATA_W-1:1]};
          carry_d = ac_q[0];
          upd_z   = 1'b1;
        end
        OP_HALT: begin
          pc_d    = pc_q;
          state_d = ST_HALT;
        end
`ifdef ACC_CPU_BRANCH_EN
        OP_JMP: begin
          pc_d = imm[ADDR_W-1:0];
        end
        OP_JZ: begin
          if (zero_q) pc_d = imm[ADDR_W-1:0];
        end
        OP_JC: begin
          if (carry_q) pc_d = imm[ADDR_W-1:0];
        end
`endif
        default: begin
          // NOP and unused opcodes only advance the PC
        end
      endcase
      if (upd_z) begin
        zero_d = (ac_d == '0);
      end
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      ac_q    <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign AC     = ac_q;
  assign PC     = pc_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_accumulator_cpu.sv
// Directed testbench for accumulator_cpu; inputs change and outputs are sampled on negedge.
module tb_accumulator_cpu;

  logic        clk;
  logic        reset;
  logic        we;
  logic [3:0]  instr_addr;
  logic [11:0] instr_in;
  logic [7:0]  AC;
  logic [3:0]  PC;
  logic        halted;

  int pass_cnt  = 0;
  int total_cnt = 0;

  accumulator_cpu dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .instr_addr (instr_addr),
    .instr_in   (instr_in),
    .AC         (AC),
    .PC         (PC),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the word is written on the following posedge
  task automatic write_word(input logic [3:0] a, input logic [11:0] w);
    we         = 1'b1;
    instr_addr = a;
    instr_in   = w;
    @(negedge clk);
  endtask

  // Reset pulse of one cycle; 'load' keeps we high so a program can follow
  task automatic do_reset(input logic load);
    @(negedge clk);
    reset = 1'b0;
    we    = load;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) write_word(4'(i), 12'h155);
    we = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (AC !== 8'h55 || PC !== 4'd2) $display("FAIL prerun AC=%h PC=%0d need AC=55 PC=2", AC, PC);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (AC !== 8'h00) $display("FAIL reset_ac got %h need 00", AC); else pass_cnt++;
    total_cnt++;
    if (PC !== 4'd0) $display("FAIL reset_pc got %0d need 0", PC); else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b0) $display("FAIL reset_halted got %b need 0", halted); else pass_cnt++;
    total_cnt++;
    if (dut.carry_q !== 1'b0 || dut.zero_q !== 1'b1)
      $display("FAIL reset_flags got C=%b Z=%b need C=0 Z=1", dut.carry_q, dut.zero_q);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs straight after reset: memory must now be all NOPs
  task automatic test_wrap();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      total_cnt++;
      if (PC !== 4'((i + 1) % 16) || AC !== 8'h00 || halted !== 1'b0)
        $display("FAIL wrap step %0d got PC=%0d AC=%h H=%b need PC=%0d AC=00 H=0",
                 i, PC, AC, halted, (i + 1) % 16);
      else pass_cnt++;
    end
  endtask

  task automatic test_program();
    logic [7:0] exp_ac [3] = '{8'h03, 8'h08, 8'h06};
    do_reset(1'b1);
    write_word(4'd0, 12'h103);
    write_word(4'd1, 12'h205);
    write_word(4'd2, 12'h302);
    write_word(4'd3, 12'hA00);
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (AC !== exp_ac[i] || PC !== 4'(i + 1) || halted !== 1'b0)
        $display("FAIL prog step %0d got AC=%h PC=%0d H=%b need AC=%h PC=%0d H=0",
                 i, AC, PC, halted, exp_ac[i], i + 1);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (AC !== 8'h06 || PC !== 4'd3 || halted !== 1'b1)
        $display("FAIL prog_halt %0d got AC=%h PC=%0d H=%b need AC=06 PC=3 H=1", i, AC, PC, halted);
      else pass_cnt++;
    end
  endtask

  task automatic test_flags();
    logic [7:0] exp_ac [4] = '{8'hFF, 8'h00, 8'h02, 8'hFF};
    logic       exp_c  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_z  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset(1'b1);
    write_word(4'd0, 12'h1FF);
    write_word(4'd1, 12'h201);
    write_word(4'd2, 12'h102);
    write_word(4'd3, 12'h303);
    write_word(4'd4, 12'hA00);
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (AC !== exp_ac[i] || dut.carry_q !== exp_c[i] || dut.zero_q !== exp_z[i])
        $display("FAIL flags step %0d got AC=%h C=%b Z=%b need AC=%h C=%b Z=%b",
                 i, AC, dut.carry_q, dut.zero_q, exp_ac[i], exp_c[i], exp_z[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_logic();
    logic [11:0] prog  [9] = '{12'h1F0, 12'h43C, 12'h505, 12'h6FF, 12'h700,
                               12'h181, 12'h800, 12'h900, 12'hA00};
    logic [7:0]  exp_ac [8] = '{8'hF0, 8'h30, 8'h35, 8'hCA, 8'h35, 8'h81, 8'h02, 8'h01};
    logic        exp_c  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) write_word(4'(i), prog[i]);
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total_cnt++;
      if (AC !== exp_ac[i] || dut.carry_q !== exp_c[i])
        $display("FAIL logic step %0d got AC=%h C=%b need AC=%h C=%b",
                 i, AC, dut.carry_q, exp_ac[i], exp_c[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (PC !== 4'd8 || halted !== 1'b1 || AC !== 8'h01)
      $display("FAIL logic_halt got PC=%0d H=%b AC=%h need PC=8 H=1 AC=01", PC, halted, AC);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    write_word(4'd0, 12'h101);
    write_word(4'd1, 12'h201);
    write_word(4'd2, 12'h201);
    write_word(4'd3, 12'h201);
    write_word(4'd4, 12'hA00);
    we = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (AC !== 8'h02 || PC !== 4'd2) $display("FAIL stall_pre got AC=%h PC=%0d need AC=02 PC=2", AC, PC);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      write_word(4'd2, 12'h210);
      total_cnt++;
      if (AC !== 8'h02 || PC !== 4'd2)
        $display("FAIL stall_hold %0d got AC=%h PC=%0d need AC=02 PC=2", i, AC, PC);
      else pass_cnt++;
    end
    we = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (AC !== 8'h12 || PC !== 4'd3) $display("FAIL stall_resume got AC=%h PC=%0d need AC=12 PC=3", AC, PC);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (AC !== 8'h13 || PC !== 4'd4) $display("FAIL stall_next got AC=%h PC=%0d need AC=13 PC=4", AC, PC);
    else pass_cnt++;
    @(negedge clk);
    write_word(4'd4, 12'h000);
    we = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (halted !== 1'b1 || PC !== 4'd4 || AC !== 8'h13)
      $display("FAIL halt_sticky got H=%b PC=%0d AC=%h need H=1 PC=4 AC=13", halted, PC, AC);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    logic [3:0] exp_pc;
`ifdef ACC_CPU_BRANCH_EN
    exp_pc = 4'd5;
`else
    exp_pc = 4'd2;
`endif
    do_reset(1'b1);
    write_word(4'd0, 12'h100);
    write_word(4'd1, 12'hC05);
    we = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (PC !== 4'd1 || AC !== 8'h00) $display("FAIL branch_pre got PC=%0d AC=%h need PC=1 AC=00", PC, AC);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (PC !== exp_pc || AC !== 8'h00 || dut.zero_q !== 1'b1)
      $display("FAIL branch_jz got PC=%0d AC=%h Z=%b need PC=%0d AC=00 Z=1", PC, AC, dut.zero_q, exp_pc);
    else pass_cnt++;
  endtask

  initial begin
    reset      = 1'b0;
    we         = 1'b0;
    instr_addr = '0;
    instr_in   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_wrap();
    test_program();
    test_flags();
    test_logic();
    test_back_to_back();
    test_branch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
